axi_sram_slave: RTL and testbench

AXI4 slave-side responder that terminates one interconnect slave port (AW/W/B and AR/R channels, S-side IDs) and drives a single-port word-addressed SRAM macro. It sits between the interconnect's slave port and an SRAM instance (IM or DM), turning AXI bursts into per-beat SRAM accesses. It is the far end of the interconnect's master-to-slave path. One transaction is outstanding at a time; reads and writes are serialized through one FSM.

---
 rtl/axi_sram_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave responder in front of a single-port, word-addressed SRAM macro.
// One transaction is in flight at a time. Reads and writes share one FSM, and
// every AXI beat becomes one SRAM access.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high. This slave holds VALID and its payload
// steady until READY arrives, and it never withdraws RVALID or BVALID early.
module axi_sram_slave #(
  parameter int SRAM_AW = 14
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  // write address channel
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  // write data channel
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  // write response channel
  output logic [`AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  // read address channel
  input  logic [`AXI_IDS_BITS-1:0]   ARID,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
  input  logic [1:0]                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  // read data channel
  output logic [`AXI_IDS_BITS-1:0]   RID,
  output logic [`AXI_DATA_BITS-1:0]  RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  // SRAM macro side
  output logic                       CEB,
  output logic                       WEB,
  output logic [31:0]                BWEB,
  output logic [SRAM_AW-1:0]         A,
  output logic [31:0]                DI,
  input  logic [31:0]                DO,
  // current FSM state, for observation only
  output logic [2:0]                 dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ACC  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  localparam int IDW    = `AXI_IDS_BITS;
  localparam int LEN_W  = `AXI_LEN_BITS;
  localparam int CNT_W  = LEN_W + 1;
  localparam int STRB_W = `AXI_STRB_BITS;

  logic [2:0]         state;
  logic [IDW-1:0]     id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         burst_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               rd_first;
  logic [31:0]        rdata_q;

  logic               aw_fire;
  logic               ar_fire;
  logic               w_fire;
  logic               r_fire;
  logic               b_fire;
  logic               beat_last;
  logic [SRAM_AW-1:0] addr_next;
  logic [31:0]        bweb_w;

  // Size fields and address bits outside the SRAM window have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, ARSIZE,
                           AWADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], AWADDR[1:0],
                           ARADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR[1:0]};

  // A write wins over a read offered in the same IDLE cycle.
  assign aw_fire   = (state == S_IDLE) && AWVALID;
  assign ar_fire   = (state == S_IDLE) && ARVALID && !AWVALID;
  assign w_fire    = (state == S_WR_DATA) && WVALID;
  assign r_fire    = (state == S_RD_DATA) && RREADY;
  assign b_fire    = (state == S_WR_RESP) && BREADY;
  assign beat_last = (cnt_q == {1'b0, len_q});
  // FIXED holds the address; INCR and WRAP step by one word and roll over.
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + {{(SRAM_AW-1){1'b0}}, 1'b1};

  // FSM, transaction registers and read-data holding register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_fire) begin
            id_q    <= AWID;
            addr_q  <= AWADDR[SRAM_AW+1:2];
            len_q   <= AWLEN;
            burst_q <= AWBURST;
            cnt_q   <= '0;
            state   <= S_WR_DATA;
          end else if (ar_fire) begin
            id_q    <= ARID;
            addr_q  <= ARADDR[SRAM_AW+1:2];
            len_q   <= ARLEN;
            burst_q <= ARBURST;
            cnt_q   <= '0;
            state   <= S_RD_ACC;
          end
        end
        S_RD_ACC: begin
          rd_first <= 1'b1;
          state    <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (rd_first) begin
            rdata_q  <= DO;
            rd_first <= 1'b0;
          end
          if (r_fire) begin
            if (beat_last) begin
              state <= S_IDLE;
            end else begin
              cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              addr_q <= addr_next;
              state  <= S_RD_ACC;
            end
          end
        end
        S_WR_DATA: begin
          if (w_fire) begin
            err_q  <= err_q | (WLAST != beat_last);
            cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            addr_q <= addr_next;
            if (WLAST) state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (b_fire) begin
            err_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte strobes expand to the active-low per-bit mask during a write beat.
  always_comb begin
    bweb_w = '1;
    if (w_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        bweb_w[8*i +: 8] = {8{~WSTRB[i]}};
      end
    end
  end

  assign AWREADY = (state == S_IDLE);
  assign ARREADY = (state == S_IDLE) && !AWVALID;
  assign WREADY  = (state == S_WR_DATA);

  assign BVALID  = (state == S_WR_RESP);
  assign BID     = id_q;
  assign BRESP   = ((state == S_WR_RESP) && err_q) ? 2'b10 : 2'b00;

  // The first data cycle passes DO straight through; after that the captured
  // copy keeps RDATA steady for as long as the master stalls.
  assign RVALID  = (state == S_RD_DATA);
  assign RID     = id_q;
  assign RRESP   = 2'b00;
  assign RLAST   = (state == S_RD_DATA) && beat_last;
  assign RDATA   = rd_first ? DO : rdata_q;

  assign CEB     = !((state == S_RD_ACC) || w_fire);
  assign WEB     = !w_fire;
  assign BWEB    = bweb_w;
  assign A       = addr_q;
  assign DI      = w_fire ? WDATA : 32'h0;

  assign dbg_state = state;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: a behavioural SRAM macro, AXI driver tasks, and
// a word-array reference model that predicts read data and write responses.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_sram_slave;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [7:0]  AWID = '0, ARID = '0, BID, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [3:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01, BRESP, RRESP;
  logic        AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic        BREADY = 1'b0, RREADY = 1'b0;
  logic [31:0] WDATA = '0, RDATA, BWEB, DI;
  logic [3:0]  WSTRB = '0;
  logic        AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, CEB, WEB;
  logic [13:0] A;
  logic [31:0] DO = '0;
  logic [2:0]  dbg_state;

  axi_sram_slave #(.SRAM_AW(14)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO),
    .dbg_state(dbg_state)
  );

  // ---------------- SRAM macro model and reference memory ----------------
  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  int sram_wr_cnt = 0;

  always @(posedge ACLK) begin
    if (!CEB) begin
      if (!WEB) begin
        sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        DO <= sram[A];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] wdata_q[$];
  logic [3:0]  wstrb_q[$];
  logic [79:0] acc_q[$];      // {CEB, WEB, A, BWEB, DI} seen on each W handshake
  logic [42:0] rd_obs_q[$];   // {RLAST, RRESP, RID, RDATA} per R handshake
  logic [42:0] exp_q[$];
  int gap_q[$];
  int aw_hs_cyc, b_hs_cyc, ar_hs_cyc, ar_polls;

  localparam logic [137:0] RST_VEC = {6'b110000, 8'h00, 2'b00, 8'h00, 2'b00, 32'h0,
                                      2'b11, 32'hFFFF_FFFF, 14'h0, 32'h0};

  function automatic logic [137:0] out_vec();
    return {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BID, BRESP, RID, RRESP,
            RDATA, CEB, WEB, BWEB, A, DI};
  endfunction

  // Reference: a burst walks words from addr[15:2]; FIXED stays put, others step mod 2^14.
  function automatic void model_read(input logic [31:0] addr, input logic [3:0] len,
                                     input logic [1:0] burst, input logic [7:0] id);
    logic [13:0] w;
    w = addr[15:2];
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back({(i == int'(len)), 2'b00, id, ref_mem[w]});
      if (burst != 2'b00) w = w + 14'd1;
    end
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [1:0] burst,
                                      input int nbeats);
    logic [13:0] w;
    w = addr[15:2];
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < 4; j++)
        if (wstrb_q[i][j]) ref_mem[w][8*j +: 8] = wdata_q[i][8*j +: 8];
      if (burst != 2'b00) w = w + 14'd1;
    end
  endfunction

  function automatic logic [1:0] model_bresp(input logic [3:0] len, input int nbeats);
    return (nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [7:0] id, input logic [1:0] burst, input int nbeats,
                           output logic [7:0] bid, output logic [1:0] bresp, output int b_gap);
    bit ok;
    int k;
    acc_q.delete();
    bid = '0; bresp = '0; b_gap = 0;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      #1; if (AWREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL aw_timeout: AWREADY=0 want 1"); AWVALID = 1'b0; return; end
    aw_hs_cyc = cyc;
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WDATA = wdata_q[i]; WSTRB = wstrb_q[i]; WLAST = (i == nbeats - 1); WVALID = 1'b1;
      ok = 0;
      for (int n = 0; n < 50; n++) begin
        #1; if (WREADY) begin ok = 1; break; end
        @(negedge ACLK);
      end
      if (!ok) begin
        total++; bad++; $display("FAIL w_timeout: WREADY=0 want 1");
        WVALID = 1'b0; WLAST = 1'b0; return;
      end
      acc_q.push_back({CEB, WEB, A, BWEB, DI});
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    k = 1;
    while (!BVALID && k < 50) begin @(negedge ACLK); k++; end
    if (!BVALID) begin total++; bad++; $display("FAIL b_timeout: BVALID=0 want 1"); return; end
    b_gap = k;
    BREADY = 1'b1; bid = BID; bresp = BRESP; b_hs_cyc = cyc;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [7:0] id, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc, output bit stable_ok);
    bit ok;
    bit last;
    int k;
    logic [43:0] snap;
    rd_obs_q.delete(); gap_q.delete();
    stable_ok = 1; ar_polls = 0;
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1; RREADY = 1'b1;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      #1; if (ARREADY) begin ok = 1; break; end
      ar_polls++;
      @(negedge ACLK);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL ar_timeout: ARREADY=0 want 1"); ARVALID = 1'b0; RREADY = 1'b0; return; end
    ar_hs_cyc = cyc;
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int b = 0; b < 17; b++) begin
      k = 1;
      while (!RVALID && k < 50) begin @(negedge ACLK); k++; end
      if (!RVALID) begin total++; bad++; $display("FAIL r_timeout: RVALID=0 want 1"); break; end
      gap_q.push_back(k);
      if (b == stall_beat && stall_cyc > 0) begin
        RREADY = 1'b0;
        snap = {RVALID, RLAST, RRESP, RID, RDATA};
        repeat (stall_cyc) begin
          @(negedge ACLK);
          if ({RVALID, RLAST, RRESP, RID, RDATA} !== snap) stable_ok = 0;
        end
        RREADY = 1'b1;
      end
      rd_obs_q.push_back({RLAST, RRESP, RID, RDATA});
      last = RLAST;
      @(negedge ACLK);
      if (last) break;
    end
    RREADY = 1'b0;
  endtask

  function automatic void fill_wdata(input int n);
    wdata_q.delete(); wstrb_q.delete();
    for (int i = 0; i < n; i++) begin
      wdata_q.push_back($urandom);
      wstrb_q.push_back(4'($urandom_range(0, 15)));
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL post_reset_idle: got %h want %h", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_single_read();
    bit st;
    sram[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
    axi_read(32'h40, 4'd0, 8'h15, 2'b01, -1, 0, st);
    model_read(32'h40, 4'd0, 2'b01, 8'h15);
    total++;
    if (rd_obs_q.size() != 1 || rd_obs_q[0] !== {1'b1, 2'b00, 8'h15, 32'hDEADBEEF}) begin
      bad++; $display("FAIL single_read: got %h want %h", rd_obs_q.size() ? rd_obs_q[0] : 43'h0,
                      {1'b1, 2'b00, 8'h15, 32'hDEADBEEF});
    end
    total++;
    if (gap_q.size() != 1 || gap_q[0] != 2) begin
      bad++; $display("FAIL single_read_latency: got %0d want 2", gap_q.size() ? gap_q[0] : -1);
    end
  endtask

  task automatic test_burst_read();
    bit st;
    axi_read(32'h100, 4'd3, 8'h07, 2'b01, 1, 3, st);
    model_read(32'h100, 4'd3, 2'b01, 8'h07);
    total++;
    if (rd_obs_q.size() != 4) begin bad++; $display("FAIL burst_read_beats: got %0d want 4", rd_obs_q.size()); end
    for (int i = 0; i < rd_obs_q.size() && i < 4; i++) begin
      total++;
      if (rd_obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_read_beat%0d: got %h want %h", i, rd_obs_q[i], exp_q[i]); end
      total++;
      if (gap_q[i] != 2) begin bad++; $display("FAIL burst_read_gap%0d: got %0d want 2", i, gap_q[i]); end
    end
    total++;
    if (!st) begin bad++; $display("FAIL burst_read_stall_stable: got 0 want 1"); end
  endtask

  task automatic test_strobed_write();
    logic [7:0] bid; logic [1:0] bresp; int bg; bit st;
    sram[14'h2] = 32'hFFFF_FFFF; ref_mem[14'h2] = 32'hFFFF_FFFF;
    wdata_q = '{32'h12345678}; wstrb_q = '{4'b0011};
    axi_write(32'h8, 4'd0, 8'h3C, 2'b01, 1, bid, bresp, bg);
    model_write(32'h8, 2'b01, 1);
    total++;
    if (acc_q.size() != 1 || acc_q[0] !== {1'b0, 1'b0, 14'h2, 32'hFFFF0000, 32'h12345678}) begin
      bad++; $display("FAIL strobe_access: got %h want %h", acc_q.size() ? acc_q[0] : 80'h0,
                      {1'b0, 1'b0, 14'h2, 32'hFFFF0000, 32'h12345678});
    end
    total++;
    if ({bid, bresp} !== {8'h3C, 2'b00}) begin bad++; $display("FAIL strobe_bresp: got %h want %h", {bid, bresp}, {8'h3C, 2'b00}); end
    total++;
    if (bg != 1) begin bad++; $display("FAIL strobe_b_latency: got %0d want 1", bg); end
    axi_read(32'h8, 4'd0, 8'h01, 2'b01, -1, 0, st);
    total++;
    if (rd_obs_q.size() != 1 || rd_obs_q[0][31:0] !== 32'hFFFF5678 || ref_mem[14'h2] !== 32'hFFFF5678) begin
      bad++; $display("FAIL strobe_readback: got %h want %h", rd_obs_q.size() ? rd_obs_q[0][31:0] : 32'h0, 32'hFFFF5678);
    end
  endtask

  task automatic test_collision();
    logic [7:0] bid; logic [1:0] bresp; int bg; bit st;
    fill_wdata(2);
    wstrb_q[0] = 4'hF; wstrb_q[1] = 4'hF;
    fork
      axi_write(32'h300, 4'd1, 8'h33, 2'b01, 2, bid, bresp, bg);
      axi_read(32'h300, 4'd1, 8'h44, 2'b01, -1, 0, st);
    join
    model_write(32'h300, 2'b01, 2);
    model_read(32'h300, 4'd1, 2'b01, 8'h44);
    total++;
    if (ar_polls == 0) begin bad++; $display("FAIL collision_arready: got 1 want 0"); end
    total++;
    if (ar_hs_cyc != b_hs_cyc + 1) begin bad++; $display("FAIL collision_order: ar_cyc=%0d want %0d", ar_hs_cyc, b_hs_cyc + 1); end
    total++;
    if ({bid, bresp} !== {8'h33, 2'b00}) begin bad++; $display("FAIL collision_bresp: got %h want %h", {bid, bresp}, {8'h33, 2'b00}); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rd_obs_q.size() != 2 || rd_obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL collision_read%0d: got %h want %h", i, rd_obs_q.size() > i ? rd_obs_q[i] : 43'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_len_error();
    logic [7:0] bid; logic [1:0] bresp; int bg; int wc; bit st;
    fill_wdata(2);
    wc = sram_wr_cnt;
    axi_write(32'h500, 4'd2, 8'h5A, 2'b01, 2, bid, bresp, bg);
    model_write(32'h500, 2'b01, 2);
    total++;
    if (sram_wr_cnt - wc != 2) begin bad++; $display("FAIL len_err_writes: got %0d want 2", sram_wr_cnt - wc); end
    total++;
    if (bresp !== model_bresp(4'd2, 2)) begin bad++; $display("FAIL len_err_bresp: got %b want 10", bresp); end
    fill_wdata(2);
    axi_write(32'h510, 4'd1, 8'h5B, 2'b01, 2, bid, bresp, bg);
    model_write(32'h510, 2'b01, 2);
    total++;
    if ({bid, bresp} !== {8'h5B, 2'b00}) begin bad++; $display("FAIL len_ok_bresp: got %h want %h", {bid, bresp}, {8'h5B, 2'b00}); end
    axi_read(32'h500, 4'd2, 8'h02, 2'b01, -1, 0, st);
    model_read(32'h500, 4'd2, 2'b01, 8'h02);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_obs_q.size() != 3 || rd_obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL len_err_readback%0d: got %h want %h", i, rd_obs_q.size() > i ? rd_obs_q[i] : 43'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_burst_modes();
    logic [7:0] bid; logic [1:0] bresp; int bg; bit st;
    // INCR across the top of the word space rolls over to word 0
    fill_wdata(4);
    axi_write(32'hFFF8, 4'd3, 8'h61, 2'b01, 4, bid, bresp, bg);
    model_write(32'hFFF8, 2'b01, 4);
    total++;
    if (acc_q.size() != 4 || acc_q[2][77:64] !== 14'h0) begin
      bad++; $display("FAIL wrap_addr: got %h want 0", acc_q.size() == 4 ? acc_q[2][77:64] : 14'h3FFF);
    end
    axi_read(32'hFFF8, 4'd3, 8'h62, 2'b10, -1, 0, st);
    model_read(32'hFFF8, 4'd3, 2'b10, 8'h62);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_obs_q.size() != 4 || rd_obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL wrap_read%0d: got %h want %h", i, rd_obs_q.size() > i ? rd_obs_q[i] : 43'h0, exp_q[i]);
      end
    end
    // FIXED read returns the same word on every beat
    axi_read(32'h640, 4'd2, 8'h63, 2'b00, 0, 2, st);
    model_read(32'h640, 4'd2, 2'b00, 8'h63);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_obs_q.size() != 3 || rd_obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL fixed_read%0d: got %h want %h", i, rd_obs_q.size() > i ? rd_obs_q[i] : 43'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok; bit st;
    int k;
    @(negedge ACLK);
    ARID = 8'h2A; ARADDR = 32'h200; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      #1; if (ARREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      k = 0;
      while (!RVALID && k < 50) begin @(negedge ACLK); k++; end
      if (b == 0) @(negedge ACLK);
    end
    total++;
    if (!ok || !RVALID) begin bad++; $display("FAIL midburst_setup: RVALID=%b want 1", RVALID); end
    #2 ARESETn = 1'b0;
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin bad++; $display("FAIL midburst_reset: got %h want %h", out_vec(), RST_VEC); end
    RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    total++;
    if (out_vec() !== RST_VEC) begin bad++; $display("FAIL midburst_held: got %h want %h", out_vec(), RST_VEC); end
    ARESETn = 1'b1;
    axi_read(32'h40, 4'd0, 8'h19, 2'b01, -1, 0, st);
    model_read(32'h40, 4'd0, 2'b01, 8'h19);
    total++;
    if (rd_obs_q.size() != 1 || rd_obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL midburst_after: got %h want %h", rd_obs_q.size() ? rd_obs_q[0] : 43'h0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] bid; logic [1:0] bresp; int bg; bit st;
    logic [31:0] addr; logic [3:0] len; logic [1:0] burst; logic [7:0] id;
    int nb; int wc;
    for (int t = 0; t < 24; t++) begin
      addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 16383)) << 2);
      len   = 4'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 2));
      id    = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        nb = int'(len) + 1;
        case ($urandom_range(0, 4))
          0: nb = int'(len) + 2;
          1: if (len > 0) nb = int'(len);
          default: ;
        endcase
        fill_wdata(nb);
        wc = sram_wr_cnt;
        axi_write(addr, len, id, burst, nb, bid, bresp, bg);
        model_write(addr, burst, nb);
        total++;
        if ({bid, bresp} !== {id, model_bresp(len, nb)}) begin
          bad++; $display("FAIL rnd_write%0d_b: got %h want %h", t, {bid, bresp}, {id, model_bresp(len, nb)});
        end
        total++;
        if (sram_wr_cnt - wc != nb) begin bad++; $display("FAIL rnd_write%0d_count: got %0d want %0d", t, sram_wr_cnt - wc, nb); end
      end else begin
        axi_read(addr, len, id, burst, $urandom_range(0, int'(len)), $urandom_range(0, 3), st);
        model_read(addr, len, burst, id);
        total++;
        if (rd_obs_q.size() != exp_q.size()) begin
          bad++; $display("FAIL rnd_read%0d_beats: got %0d want %0d", t, rd_obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < rd_obs_q.size() && i < exp_q.size(); i++) begin
          total++;
          if (rd_obs_q[i] !== exp_q[i] || gap_q[i] != 2) begin
            bad++; $display("FAIL rnd_read%0d_beat%0d: got %h gap %0d want %h gap 2", t, i, rd_obs_q[i], gap_q[i], exp_q[i]);
          end
        end
        total++;
        if (!st) begin bad++; $display("FAIL rnd_read%0d_stable: got 0 want 1", t); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_single_read();
    test_burst_read();
    test_strobed_write();
    test_collision();
    test_len_error();
    test_burst_modes();
    test_reset_midburst();
    test_random();
    repeat (2) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
